// File: rtl/fp32_to_fixed.sv
// fp32_to_fixed: iterative FP32 to signed fixed-point converter; define FP32_TO_FIXED_ROUND_EN for round-to-nearest-even
module fp32_to_fixed #(
  parameter int OUT_W = 32,
  parameter int FRAC_W = 16,
  parameter int SHIFT_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_inv
);
  localparam int ACC_W = OUT_W + 24;
  localparam logic [OUT_W-1:0] MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] MIN = {1'b1, {(OUT_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, SHIFT, FIX, OUT} state_t;
  state_t state;
  logic sign, sat, inv, left, nan, ksat, kzero, special, ovf;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [ACC_W:0] mag;
  logic [OUT_W-1:0] mag_lo;
  logic [6:0] rem, step, kabs;
  logic [7:0] exp, eff;
  logic [23:0] sig;
  logic signed [10:0] k;
`ifdef FP32_TO_FIXED_ROUND_EN
  logic guard, sticky, g_nx, s_nx, inc;
  logic [ACC_W-1:0] lo_mask;
`endif
  always_comb begin
    exp = in_data[30:23];
    eff = exp == 8'd0 ? 8'd1 : exp;
    sig = {|exp, in_data[22:0]};
    k = $signed({3'b0, eff}) - 11'sd150 + $signed(11'(FRAC_W));
    kabs = k[10] ? 7'(-k) : k[6:0];
    nan = &exp & |in_data[22:0];
    ksat = k >= $signed(11'(OUT_W));
    kzero = k <= -11'sd26;
    special = &exp | ksat | kzero;
    step = rem > 7'(SHIFT_STEP) ? 7'(SHIFT_STEP) : rem;
    acc_nx = left ? acc << step : acc >> step;
`ifdef FP32_TO_FIXED_ROUND_EN
    lo_mask = (ACC_W'(1) << step) - ACC_W'(1);
    g_nx = |(acc & (lo_mask ^ (lo_mask >> 1)));
    s_nx = sticky | guard | |(acc & (lo_mask >> 1));
    inc = guard & (sticky | acc[0]);
    mag = {1'b0, acc} + {{ACC_W{1'b0}}, inc};
`else
    mag = {1'b0, acc};
`endif
    mag_lo = mag[OUT_W-1:0];
    ovf = sat | |mag[ACC_W:OUT_W] | (mag[OUT_W-1] & (!sign | |mag[OUT_W-2:0]));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_inv <= 1'b0;
      acc <= '0;
      rem <= '0;
      sign <= 1'b0;
      sat <= 1'b0;
      inv <= 1'b0;
      left <= 1'b0;
`ifdef FP32_TO_FIXED_ROUND_EN
      guard <= 1'b0;
      sticky <= 1'b0;
`endif
    end else
      case (state)
        IDLE: if (in_valid) begin
          sign <= in_data[31];
          inv <= nan;
          sat <= !nan & (&exp | ksat);
          acc <= special ? '0 : ACC_W'(sig);
          rem <= special ? '0 : kabs;
          left <= !k[10];
`ifdef FP32_TO_FIXED_ROUND_EN
          guard <= 1'b0;
          sticky <= kzero & |sig;
`endif
          in_ready <= 1'b0;
          state <= SHIFT;
        end
        SHIFT: begin
          acc <= acc_nx;
          rem <= rem - step;
`ifdef FP32_TO_FIXED_ROUND_EN
          guard <= left ? guard : g_nx;
          sticky <= left ? sticky : s_nx;
`endif
          if (rem == step) state <= FIX;
        end
        FIX: begin
          out_data <= inv ? '0 : ovf ? (sign ? MIN : MAX) : sign ? -mag_lo : mag_lo;
          out_ovf <= !inv & ovf;
          out_inv <= inv;
          out_valid <= 1'b1;
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fp32_to_fixed.sv
// tb_fp32_to_fixed: directed-vector bench for fp32_to_fixed with default parameters
module tb_fp32_to_fixed;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_ovf, out_inv;
  logic [31:0] in_data = '0, out_data;
  int n_checks = 0, n_fail = 0;
`ifdef FP32_TO_FIXED_ROUND_EN
  localparam logic [31:0] RND = 32'h2;
`else
  localparam logic [31:0] RND = 32'h1;
`endif
  always #5 clk = ~clk;
  fp32_to_fixed dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_inv(out_inv)
  );
  task automatic drive(input logic [31:0] d, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    in_data = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask
  task automatic wait_idle();
    for (int n = 0; n < 50 && !in_ready; n++) @(negedge clk);
  endtask
  task automatic test_reset();
    #12;
    n_checks += 5;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
    if (out_inv !== 1'b0) begin n_fail++; $display("FAIL reset_out_inv got %b want 0", out_inv); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_convert();
    logic [31:0] vin [16], vout [16];
    logic vovf [16], vinv [16];
    int vlat [16];
    int lat;
    vin  = '{32'h3F800000, 32'hC0200000, 32'h47800000, 32'hC7000000, 32'h7FC00000, 32'h7F800000,
             32'hFF800000, 32'h37C00000, 32'h42C98000, 32'h44800000, 32'h80000000, 32'h00000000,
             32'h46FFFFFE, 32'hC7000001, 32'h36800000, 32'h36000000};
    vout = '{32'h00010000, 32'hFFFD8000, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h7FFFFFFF,
             32'h80000000, RND, 32'h0064C000, 32'h04000000, 32'h0, 32'h0,
             32'h7FFFFF00, 32'h80000000, 32'h0, 32'h0};
    vovf = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    vinv = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vlat = '{3, 3, 4, 3, 2, 2, 2, 7, 2, 2, 2, 2, 3, 3, 8, 2};
    for (int i = 0; i < 16; i++) begin
      drive(vin[i], lat);
      n_checks += 4;
      if (lat != vlat[i]) begin n_fail++; $display("FAIL latency in=%h got %0d want %0d", vin[i], lat, vlat[i]); end
      if (out_data !== vout[i]) begin n_fail++; $display("FAIL data in=%h got %h want %h", vin[i], out_data, vout[i]); end
      if (out_ovf !== vovf[i]) begin n_fail++; $display("FAIL ovf in=%h got %b want %b", vin[i], out_ovf, vovf[i]); end
      if (out_inv !== vinv[i]) begin n_fail++; $display("FAIL inv in=%h got %b want %b", vin[i], out_inv, vinv[i]); end
    end
  endtask
  task automatic test_backpressure();
    int lat;
    wait_idle();
    out_ready = 1'b0;
    in_data = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_data = 32'hC0200000;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      n_checks += 3;
      if (out_data !== 32'h00010000) begin n_fail++; $display("FAIL bp_hold_data cyc=%0d got %h want 00010000", c, out_data); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc=%0d got %b want 1", c, out_valid); end
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", c, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    n_checks += 2;
    if (lat != 3) begin n_fail++; $display("FAIL bp_second_latency got %0d want 3", lat); end
    if (out_data !== 32'hFFFD8000) begin n_fail++; $display("FAIL bp_second_data got %h want fffd8000", out_data); end
  endtask
  task automatic test_reset_mid();
    int lat;
    logic seen;
    wait_idle();
    @(negedge clk);
    in_data = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_in_ready got %b want 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_valid got %b want 0", out_valid); end
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_out_data got %h want 0", out_data); end
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_ovf got %b want 0", out_ovf); end
    if (out_inv !== 1'b0) begin n_fail++; $display("FAIL mid_reset_out_inv got %b want 0", out_inv); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale_valid got %b want 0", seen); end
    drive(32'h3F800000, lat);
    n_checks += 2;
    if (lat != 3) begin n_fail++; $display("FAIL after_reset_latency got %0d want 3", lat); end
    if (out_data !== 32'h00010000) begin n_fail++; $display("FAIL after_reset_data got %h want 00010000", out_data); end
  endtask
  initial begin
    test_reset();
    test_convert();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
